// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-file field width, the hard-wired
// zero register, the mult/div sequencer state encoding and its counter width.
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;
  localparam int MD_CNT_W = 6;

  typedef enum logic {
    IDLE,
    MD_BUSY
  } md_state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle of signals between the ID/EX boundary logic and the hazard controller.
// The master side is the pipeline, which supplies the decode and execute fields.
// The slave side is the controller, which returns the stall, flush and mult/div status.
interface hazard_controller_if;
  import pipeline_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_md_use;
  logic [REG_W-1:0] ex_rw;
  logic             ex_mem_read;
  logic             ex_md_start;
  logic             ex_redirect;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             md_busy;
  logic             md_done;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_md_use,
    output ex_rw, ex_mem_read, ex_md_start, ex_redirect,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    input  md_busy, md_done
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_md_use,
    input  ex_rw, ex_mem_read, ex_md_start, ex_redirect,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    output md_busy, md_done
  );

endinterface

// File: rtl/muldiv_seq.sv
// Mult/div occupancy sequencer. A start moves the FSM to MD_BUSY for
// MULDIV_CYCLES cycles. On the cycle after that, md_done pulses for one cycle.
// A start that arrives while the unit is busy is ignored. Upstream stalling
// keeps that case from happening.
module muldiv_seq
  import pipeline_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic md_busy,
  output logic md_done
);

  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MULDIV_CYCLES - 1);

  md_state_t             state;
  logic [MD_CNT_W-1:0]   cnt;

  // State, down-counter and the registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= CNT_LOAD;
            state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) begin
            state   <= IDLE;
            md_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer. It detects load-use hazards that forwarding
// cannot cover, tracks mult/div occupancy, and resolves EX redirects into
// stall and flush controls for the PC, IF/ID and ID/EX registers.
// The mult/div sequencing is present only when HAZARD_MULDIV_EN is defined.
// Without it, only the load-use and redirect logic remain.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_controller_if.slave  hif
);

  logic load_use;
  logic md_hazard;
  logic stall;

`ifdef HAZARD_MULDIV_EN
  logic md_busy_q;
  logic md_done_q;

  muldiv_seq #(
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_muldiv_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (hif.ex_md_start),
    .md_busy (md_busy_q),
    .md_done (md_done_q)
  );

  assign md_hazard   = hif.id_md_use && (md_busy_q || hif.ex_md_start);
  assign hif.md_busy = md_busy_q;
  assign hif.md_done = md_done_q;
`else
  logic unused_md_inputs;
  assign unused_md_inputs = ^{clk, rst_n, hif.ex_md_start, hif.id_md_use};

  assign md_hazard   = 1'b0;
  assign hif.md_busy = 1'b0;
  assign hif.md_done = 1'b0;
`endif

  assign load_use = hif.ex_mem_read && (hif.ex_rw != ZERO_REG) &&
                    ((hif.ex_rw == hif.id_rs) ||
                     (hif.id_uses_rt && (hif.ex_rw == hif.id_rt)));

  assign stall = load_use || md_hazard;

  // A redirect makes the ID instruction wrong-path, so it overrides any stall
  always_comb begin
    hif.pc_stall    = 1'b0;
    hif.if_id_stall = 1'b0;
    hif.if_id_flush = 1'b0;
    hif.id_ex_flush = 1'b0;
    if (hif.ex_redirect) begin
      hif.if_id_flush = 1'b1;
      hif.id_ex_flush = 1'b1;
    end else if (stall) begin
      hif.pc_stall    = 1'b1;
      hif.if_id_stall = 1'b1;
      hif.id_ex_flush = 1'b1;
    end
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard sequencer for the 5-stage core. It detects load-use hazards that forwarding cannot cover, sequences the multi-cycle multiply/divide unit, and resolves taken branches and jumps. It drives stall and flush controls into the PC, IF/ID and ID/EX registers. It sits beside the forwarding unit in the ID/EX boundary logic; forwarding handles everything this block does not stall.

## Interface
Parameters:
- MULDIV_CYCLES, default 32: cycles the mult/div unit is occupied per operation; legal range 2..64.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source (R-type, store, branch compare).
- id_md_use  in  1  the ID instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu.
- ex_rw  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_md_start  in  1  a valid (non-bubble) mult/div is in EX this cycle.
- ex_redirect  in  1  a branch taken or jump resolved in EX this cycle.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  clear IF/ID to a bubble.
- id_ex_flush  out  1  load a bubble into ID/EX.
- md_busy  out  1  registered: the mult/div unit is occupied.
- md_done  out  1  registered one-cycle pulse: hi/lo result is valid.

## Operation
- load_use = ex_mem_read && ex_rw != 0 && (ex_rw == id_rs || (id_uses_rt && ex_rw == id_rt)).
- md_hazard = id_md_use && (state == MD_BUSY || ex_md_start).
- stall = load_use || md_hazard.
- Priority rules:
  - ex_redirect wins over everything: if_id_flush=1, id_ex_flush=1, pc_stall=0, if_id_stall=0. The ID instruction is wrong-path, so its hazards are ignored.
  - Else, if stall: pc_stall=1, if_id_stall=1, id_ex_flush=1, if_id_flush=0.
  - Else all four controls are 0.
- FSM states:
  - IDLE: on ex_md_start, load cnt=MULDIV_CYCLES-1 and go to MD_BUSY.
  - MD_BUSY: cnt decrements each cycle. When cnt==0, go to IDLE and register md_done=1 for exactly one cycle.
  - ex_md_start while in MD_BUSY is unreachable, because md_hazard stalls the instruction in ID. If it is asserted anyway, it is ignored and flagged by the assertion in the test plan.
- ex_redirect does not cancel an operation in progress; the mult/div already issued is architecturally committed.
- cnt is 6 bits, unsigned, and never wraps below 0.
- md_busy = (state == MD_BUSY).

## Timing
- pc_stall, if_id_stall, if_id_flush and id_ex_flush are combinational from the current inputs and state, and are valid in the same cycle.
- Load-use stall lasts exactly 1 cycle. Next cycle the load is in MEM and the forwarding unit supplies the data.
- A mult/div entering EX at cycle T:
  - md_busy=1 during cycles T+1 .. T+MULDIV_CYCLES.
  - md_done=1 during cycle T+MULDIV_CYCLES+1, with md_busy=0 in that cycle.
  - A dependent id_md_use stalls in cycles T .. T+MULDIV_CYCLES and issues in T+MULDIV_CYCLES+1.
- Reset (asynchronous, any time, including mid-operation): state=IDLE, cnt=0, md_busy=0, md_done=0. Combinational outputs follow the inputs, so they are 0 when all inputs are 0.
- Release is synchronous to clk.

## Configuration
- HAZARD_MULDIV_EN defined: mult/div FSM, counter, md_hazard, md_busy and md_done are present as described.
- HAZARD_MULDIV_EN undefined:
  - ex_md_start and id_md_use are ignored.
  - md_hazard=0; md_busy and md_done are tied to 0.
  - Only load-use and redirect logic remain.

## Structure
- Shared package pipeline_pkg holds:
  - REG_W=5 and ZERO_REG=5'd0.
  - the md_state_t enum {IDLE, MD_BUSY}.
  - the MD_CNT_W=6 constant.
- One sub-module, muldiv_seq: FSM plus counter, producing md_busy and md_done. It is instantiated only under HAZARD_MULDIV_EN.
- The top level contains the combinational hazard and priority logic.

## Test plan
- Load-use on rs: ex_mem_read=1, ex_rw=8, id_rs=8 → pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle. Repeat with ex_rw=0 → no stall.
- rt gating: ex_mem_read=1, ex_rw=9, id_rt=9 → stall when id_uses_rt=1, none when id_uses_rt=0.
- Redirect priority: load_use true and ex_redirect=1 in the same cycle → if_id_flush=id_ex_flush=1, pc_stall=if_id_stall=0.
- Mult/div sequencing with MULDIV_CYCLES=4:
  - ex_md_start pulse at T → md_busy=1 for T+1..T+4, md_done=1 at T+5 only.
  - id_md_use held high → stall during T..T+4, released at T+5.
- Reset mid-operation: assert rst_n=0 at T+2 of a mult/div → md_busy and md_done drop to 0 immediately. After release, id_md_use does not stall.
- Macro off: ex_md_start=1 with id_md_use=1 → no stall, md_busy stays 0. Separately, an assertion checks ex_md_start never fires while md_busy=1.
